// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use
// hazard detection, flush, hold and a bubble counter.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          flush,
   input  logic [4:0]    rs_id,
   input  logic [4:0]    rt_id,
   input  logic [4:0]    rd_id,
   input  logic          uses_rs_id,
   input  logic          uses_rt_id,
   input  logic [DW-1:0] a_id,
   input  logic [DW-1:0] b_id,
   input  logic [DW-1:0] imm_id,
   input  logic          WB_id,
   input  logic          MemRead_id,
   input  logic          MemWrite_id,
   input  logic          ALUSrc_id,
   input  logic [3:0]    ALUOp_id,
   input  logic          RegDst_id,
   input  logic          valid_id,
   output logic [4:0]    Rs_ex,
   output logic [4:0]    Rt_ex,
   output logic [4:0]    R_dest_ex,
   output logic [DW-1:0] a_ex,
   output logic [DW-1:0] b_ex,
   output logic [DW-1:0] imm_ex,
   output logic          WB_ex,
   output logic          MemRead_ex,
   output logic          MemWrite_ex,
   output logic          ALUSrc_ex,
   output logic [3:0]    ALUOp_ex,
   output logic          valid_ex,
   output logic          stall_if_id,
   output logic [CW-1:0] bubble_cnt
);

   typedef struct packed {
      logic          valid;
      logic          wb;
      logic          mem_rd;
      logic          mem_wr;
      logic          alu_src;
      logic [3:0]    alu_op;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    rdst;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
   } ex_t;

   ex_t           ex_q, ex_d, cap;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_use;
   logic          rs_hit, rt_hit;

   // hazard detection against the load currently in EX
   always_comb begin
      rs_hit   = uses_rs_id & (rs_id == ex_q.rdst);
      rt_hit   = uses_rt_id & (rt_id == ex_q.rdst);
      load_use = ex_q.mem_rd & ex_q.valid
               & (ex_q.rdst != 5'd0)
               & (rs_hit | rt_hit) & valid_id;
   end

   assign stall_if_id = hold | (load_use & ~flush);

   // bundle the ID-side fields as they would be captured
   always_comb begin
      cap.valid   = valid_id;
      cap.wb      = WB_id;
      cap.mem_rd  = MemRead_id;
      cap.mem_wr  = MemWrite_id;
      cap.alu_src = ALUSrc_id;
      cap.alu_op  = ALUOp_id;
      cap.rs      = rs_id;
      cap.rt      = rt_id;
      cap.rdst    = RegDst_id ? rd_id : rt_id;
      cap.a       = a_id;
      cap.b       = b_id;
      cap.imm     = imm_id;
   end

   // next state: hold > flush > load-use bubble > capture
   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (hold) begin
         ex_d = ex_q;
      end else if (flush) begin
         ex_d = '0;
      end else if (load_use) begin
         ex_d = '0;
         if (cnt_q != {CW{1'b1}})
            cnt_d = cnt_q + CW'(1);
      end else if (valid_id) begin
         ex_d = cap;
      end else begin
         ex_d = '0;
      end
   end

   // pipeline register and counter state
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign valid_ex    = ex_q.valid;
   assign WB_ex       = ex_q.wb;
   assign MemRead_ex  = ex_q.mem_rd;
   assign MemWrite_ex = ex_q.mem_wr;
   assign ALUSrc_ex   = ex_q.alu_src;
   assign ALUOp_ex    = ex_q.alu_op;
   assign Rs_ex       = ex_q.rs;
   assign Rt_ex       = ex_q.rt;
   assign R_dest_ex   = ex_q.rdst;
   assign a_ex        = ex_q.a;
   assign b_ex        = ex_q.b;
   assign imm_ex      = ex_q.imm;
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of
// id_ex_stage against a behavioural EX-slot model.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          reset, hold, flush;
   logic [4:0]    rs_id, rt_id, rd_id;
   logic          uses_rs_id, uses_rt_id;
   logic [DW-1:0] a_id, b_id, imm_id;
   logic          WB_id, MemRead_id, MemWrite_id, ALUSrc_id;
   logic [3:0]    ALUOp_id;
   logic          RegDst_id, valid_id;
   logic [4:0]    Rs_ex, Rt_ex, R_dest_ex;
   logic [DW-1:0] a_ex, b_ex, imm_ex;
   logic          WB_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex;
   logic [3:0]    ALUOp_ex;
   logic          valid_ex, stall_if_id;
   logic [CW-1:0] bubble_cnt;

   id_ex_stage #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
      .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
      .a_id(a_id), .b_id(b_id), .imm_id(imm_id),
      .WB_id(WB_id), .MemRead_id(MemRead_id),
      .MemWrite_id(MemWrite_id), .ALUSrc_id(ALUSrc_id),
      .ALUOp_id(ALUOp_id), .RegDst_id(RegDst_id),
      .valid_id(valid_id),
      .Rs_ex(Rs_ex), .Rt_ex(Rt_ex), .R_dest_ex(R_dest_ex),
      .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex),
      .WB_ex(WB_ex), .MemRead_ex(MemRead_ex),
      .MemWrite_ex(MemWrite_ex), .ALUSrc_ex(ALUSrc_ex),
      .ALUOp_ex(ALUOp_ex), .valid_ex(valid_ex),
      .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v, wb, mr, mw, as;
      logic [3:0]    op;
      logic [4:0]    rs, rt, rd;
      logic [DW-1:0] a, b, imm;
   } slot_t;

   slot_t m;
   int    mcnt;
   int    checks = 0;
   int    failures = 0;

   function automatic slot_t dut_vec();
      return {valid_ex, WB_ex, MemRead_ex, MemWrite_ex,
              ALUSrc_ex, ALUOp_ex, Rs_ex, Rt_ex, R_dest_ex,
              a_ex, b_ex, imm_ex};
   endfunction

   // the ID instruction reads the register the EX load writes
   function automatic bit m_hazard();
      bit dep;
      dep = (uses_rs_id && rs_id == m.rd) ||
            (uses_rt_id && rt_id == m.rd);
      return m.v && m.mr && m.rd != 0 && valid_id && dep;
   endfunction

   function automatic bit m_stall();
      return hold || (m_hazard() && !flush);
   endfunction

   function automatic void m_step();
      slot_t n;
      n = '0;
      if (reset) begin
         m = '0;
         mcnt = 0;
      end else if (hold) begin
         m = m;
      end else if (flush) begin
         m = '0;
      end else if (m_hazard()) begin
         m = '0;
         if (mcnt < CMAX) mcnt++;
      end else if (!valid_id) begin
         m = '0;
      end else begin
         n.v = 1; n.wb = WB_id; n.mr = MemRead_id;
         n.mw = MemWrite_id; n.as = ALUSrc_id;
         n.op = ALUOp_id; n.rs = rs_id; n.rt = rt_id;
         n.rd = RegDst_id ? rd_id : rt_id;
         n.a = a_id; n.b = b_id; n.imm = imm_id;
         m = n;
      end
   endfunction

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(
      input logic v, input logic [4:0] rs, rt, rd,
      input logic urs, urt, wb, mr, mw, as,
      input logic [3:0] op, input logic rdst,
      input logic [DW-1:0] a, b, imm);
      valid_id = v; rs_id = rs; rt_id = rt; rd_id = rd;
      uses_rs_id = urs; uses_rt_id = urt;
      WB_id = wb; MemRead_id = mr; MemWrite_id = mw;
      ALUSrc_id = as; ALUOp_id = op; RegDst_id = rdst;
      a_id = a; b_id = b; imm_id = imm;
   endtask

   // lw dst, imm(src)
   task automatic drive_load(input logic [4:0] dst, src);
      drive_id(1, src, dst, 5'd0, 1, 0, 1, 1, 0, 1, 4'h0, 0,
               $urandom, $urandom, $urandom);
   endtask

   // add rd, rs, rt
   task automatic drive_add(input logic [4:0] rd, rs, rt);
      drive_id(1, rs, rt, rd, 1, 1, 1, 0, 0, 0, 4'h2, 1,
               $urandom, $urandom, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1; hold = 0; flush = 0;
      drive_add(5'd7, 5'd6, 5'd5);
      MemRead_id = 1;
      tick();
      tick();
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         failures++;
         $display("FAIL reset_regs got=%h exp=0", dut_vec());
      end
      checks++;
      if (bubble_cnt !== '0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt);
      end
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=0", stall_if_id);
      end
      reset = 0;
   endtask

   task automatic test_passthrough();
      drive_id(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 4'h2, 1,
               32'h10, 32'h20, 32'h0);
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL pass_stall got=%b exp=0", stall_if_id);
      end
      tick();
      checks++;
      if (R_dest_ex !== 5'd3 || a_ex !== 32'h10 ||
          b_ex !== 32'h20 || WB_ex !== 1'b1 ||
          valid_ex !== 1'b1) begin
         failures++;
         $display("FAIL pass_fields got=%h exp=%h",
                  dut_vec(), m);
      end
      checks++;
      if (dut_vec() !== m) begin
         failures++;
         $display("FAIL pass_all got=%h exp=%h", dut_vec(), m);
      end
   endtask

   task automatic test_load_use();
      drive_load(5'd5, 5'd1);
      tick();
      drive_add(5'd8, 5'd5, 5'd2);
      #1;
      checks++;
      if (stall_if_id !== 1'b1) begin
         failures++;
         $display("FAIL lu_stall got=%b exp=1", stall_if_id);
      end
      tick();
      checks++;
      if (dut_vec() !== '0 || bubble_cnt !== 4'd1) begin
         failures++;
         $display("FAIL lu_bubble got=%h cnt=%0d exp=0 cnt=1",
                  dut_vec(), bubble_cnt);
      end
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL lu_release got=%b exp=0", stall_if_id);
      end
      tick();
      checks++;
      if (Rs_ex !== 5'd5 || dut_vec() !== m) begin
         failures++;
         $display("FAIL lu_capture got=%h exp=%h", dut_vec(), m);
      end
   endtask

   task automatic test_reg0_unused();
      int c0;
      c0 = mcnt;
      drive_load(5'd0, 5'd1);
      tick();
      drive_add(5'd4, 5'd0, 5'd3);
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL r0_stall got=%b exp=0", stall_if_id);
      end
      tick();
      drive_load(5'd5, 5'd1);
      tick();
      drive_add(5'd4, 5'd1, 5'd5);
      uses_rt_id = 0;
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL unused_stall got=%b exp=0", stall_if_id);
      end
      tick();
      checks++;
      if (int'(bubble_cnt) !== c0 || valid_ex !== 1'b1) begin
         failures++;
         $display("FAIL unused_cnt got=%0d/%b exp=%0d/1",
                  bubble_cnt, valid_ex, c0);
      end
   endtask

   task automatic test_hold_flush();
      slot_t saved;
      int c0;
      drive_load(5'd7, 5'd2);
      tick();
      saved = m;
      c0 = mcnt;
      drive_add(5'd9, 5'd7, 5'd1);
      hold = 1; flush = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (stall_if_id !== 1'b1) begin
            failures++;
            $display("FAIL hold_stall[%0d] got=%b exp=1",
                     i, stall_if_id);
         end
         tick();
         checks++;
         if (dut_vec() !== saved || int'(bubble_cnt) !== c0) begin
            failures++;
            $display("FAIL hold_keep[%0d] got=%h/%0d exp=%h/%0d",
                     i, dut_vec(), bubble_cnt, saved, c0);
         end
      end
      hold = 0;
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL flush_stall got=%b exp=0", stall_if_id);
      end
      tick();
      checks++;
      if (dut_vec() !== '0 || int'(bubble_cnt) !== c0) begin
         failures++;
         $display("FAIL flush_bubble got=%h/%0d exp=0/%0d",
                  dut_vec(), bubble_cnt, c0);
      end
      flush = 0;
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = mcnt;
      drive_load(5'd4, 5'd1);
      tick();
      drive_load(5'd6, 5'd2);
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL b2b_load2 got=%b exp=0", stall_if_id);
      end
      tick();
      drive_add(5'd10, 5'd6, 5'd3);
      tick();
      tick();
      checks++;
      if (int'(bubble_cnt) !== c0 + 1 || Rs_ex !== 5'd6 ||
          dut_vec() !== m) begin
         failures++;
         $display("FAIL b2b_one got=%0d/%h exp=%0d/%h",
                  bubble_cnt, dut_vec(), c0 + 1, m);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive_load(5'd9, 5'd1);
         tick();
         drive_add(5'd3, 5'd2, 5'd9);
         tick();
         checks++;
         if (int'(bubble_cnt) !== mcnt) begin
            failures++;
            $display("FAIL sat_step[%0d] got=%0d exp=%0d",
                     i, bubble_cnt, mcnt);
         end
      end
      checks++;
      if (bubble_cnt !== 4'd15) begin
         failures++;
         $display("FAIL sat_final got=%0d exp=15", bubble_cnt);
      end
   endtask

   task automatic test_reset_mid_stall();
      drive_load(5'd5, 5'd2);
      tick();
      drive_add(5'd1, 5'd5, 5'd5);
      reset = 1;
      tick();
      #1;
      checks++;
      if (dut_vec() !== '0 || bubble_cnt !== '0 ||
          stall_if_id !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got=%h/%0d/%b exp=0/0/0",
                  dut_vec(), bubble_cnt, stall_if_id);
      end
      reset = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 5) == 0);
         drive_id($urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0,
                  1'($urandom), 1'($urandom),
                  4'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom);
         #1;
         checks++;
         if (stall_if_id !== m_stall()) begin
            failures++;
            $display("FAIL rnd_stall[%0d] got=%b exp=%b",
                     i, stall_if_id, m_stall());
         end
         tick();
         checks++;
         if (dut_vec() !== m || int'(bubble_cnt) !== mcnt) begin
            failures++;
            $display("FAIL rnd_state[%0d] got=%h/%0d exp=%h/%0d",
                     i, dut_vec(), bubble_cnt, m, mcnt);
         end
      end
      reset = 0; hold = 0; flush = 0;
   endtask

   initial begin
      m = '0;
      mcnt = 0;
      test_reset();
      test_passthrough();
      test_load_use();
      test_reg0_unused();
      test_hold_flush();
      test_back_to_back();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
